// File: rtl/imem_fetch.sv
// imem_fetch: byte-addressable little-endian instruction memory with load port and registered fetch response
module imem_fetch #(
    parameter int          DEPTH_BYTES = 256,
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] NOP_INST    = 32'h00000013,
    parameter int          CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic [3:0]        ld_be,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_inst,
    output logic [ADDR_W-1:0] rsp_pc,
    output logic [1:0]        rsp_fault,
    output logic [CNT_W-1:0]  fetch_cnt
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH_BYTES);

    logic [7:0]  mem [DEPTH_BYTES];
    logic        ld_hit, accept;
    logic [31:0] rd_word;
    logic [1:0]  fault;

    assign ld_hit    = ld_valid && ({1'b0, ld_addr[ADDR_W-1:2], 2'b00} < LIM);
    assign req_ready = !ld_valid && !flush && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rd_word   = {mem[{req_pc[AW-1:2], 2'd3}], mem[{req_pc[AW-1:2], 2'd2}],
                        mem[{req_pc[AW-1:2], 2'd1}], mem[{req_pc[AW-1:2], 2'd0}]};
    // range check is one bit wider than the PC so a PC near the top cannot wrap to a valid index
    assign fault = (req_pc[1:0] != 2'b00) ? 2'b01 :
                   (({1'b0, req_pc} + (ADDR_W+1)'(3)) >= LIM) ? 2'b10 : 2'b00;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ld_hit && ld_be[i]) mem[{ld_addr[AW-1:2], 2'(i)}] <= ld_data[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_inst  <= NOP_INST;
            rsp_pc    <= '0;
            rsp_fault <= 2'b00;
            fetch_cnt <= '0;
        end else begin
            if (rsp_valid && rsp_ready && fetch_cnt != '1) fetch_cnt <= fetch_cnt + 1'b1;
            if (flush) begin
                rsp_valid <= 1'b0;
            end else if (accept) begin
                rsp_valid <= 1'b1;
                rsp_pc    <= req_pc;
                rsp_fault <= fault;
                rsp_inst  <= (fault == 2'b00) ? rd_word : NOP_INST;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: scoreboard bench for imem_fetch with a byte-array reference model
module tb_imem_fetch;
    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset, ld_valid, req_valid, rsp_ready, flush;
    logic [31:0] ld_addr, ld_data, req_pc;
    logic [3:0]  ld_be;
    logic        req_ready, rsp_valid;
    logic [31:0] rsp_inst, rsp_pc;
    logic [1:0]  rsp_fault;
    logic [15:0] fetch_cnt;
    logic        s_req_ready, s_rsp_valid;
    logic [31:0] s_rsp_inst, s_rsp_pc;
    logic [1:0]  s_rsp_fault, s_cnt;

    imem_fetch #(.DEPTH_BYTES(DEPTH)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_be(ld_be), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst),
        .rsp_pc(rsp_pc), .rsp_fault(rsp_fault), .fetch_cnt(fetch_cnt)
    );

    imem_fetch #(.DEPTH_BYTES(DEPTH), .CNT_W(2)) u_small (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_be(ld_be), .req_valid(req_valid), .req_ready(s_req_ready), .req_pc(req_pc),
        .flush(flush), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(s_rsp_inst),
        .rsp_pc(s_rsp_pc), .rsp_fault(s_rsp_fault), .fetch_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  fault;
    } rsp_t;

    rsp_t       exp_q[$];
    logic [7:0] mem_m [DEPTH];
    bit         m_valid, m_cons, m_rdy;
    int         m_cnt;
    int         checks = 0, passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic rsp_t expect_rsp(input logic [31:0] pc);
        rsp_t r;
        r.pc = pc;
        if (pc[1:0] != 2'b00) begin
            r.inst = NOP; r.fault = 2'b01;
        end else if (longint'(pc) + 3 >= DEPTH) begin
            r.inst = NOP; r.fault = 2'b10;
        end else begin
            r.inst = {mem_m[pc+3], mem_m[pc+2], mem_m[pc+1], mem_m[pc]}; r.fault = 2'b00;
        end
        return r;
    endfunction

    // reference model: advances at each rising edge from the inputs held across it
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete(); m_valid = 0; m_cnt = 0;
        end else begin
            m_cons = m_valid && rsp_ready;
            m_rdy  = !ld_valid && !flush && (!m_valid || rsp_ready);
            if (m_cons && m_cnt < 65535) m_cnt++;
            if (flush) begin
                m_valid = 0; exp_q.delete();
            end else if (req_valid && m_rdy) begin
                exp_q.push_back(expect_rsp(req_pc)); m_valid = 1;
            end else if (m_cons) m_valid = 0;
            if (ld_valid && (ld_addr & ~32'd3) < DEPTH)
                for (int k = 0; k < 4; k++)
                    if (ld_be[k]) mem_m[(ld_addr & ~32'd3) + k] = ld_data[8*k +: 8];
        end
    end

    // monitor: compares whatever the DUT presents against the scoreboard head
    always @(negedge clk) begin
        chk("rsp_valid", rsp_valid, m_valid);
        chk("req_ready", req_ready, !ld_valid && !flush && (!m_valid || rsp_ready));
        chk("fetch_cnt", fetch_cnt, m_cnt);
        chk("sat_cnt", s_cnt, (m_cnt > 3) ? 3 : m_cnt);
        if (rsp_valid) begin
            chk("rsp_pending", exp_q.size(), 1);
            if (exp_q.size() != 0) begin
                chk("rsp_inst", rsp_inst, exp_q[0].inst);
                chk("rsp_pc", rsp_pc, exp_q[0].pc);
                chk("rsp_fault", rsp_fault, exp_q[0].fault);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        ld_valid = 1; ld_addr = a; ld_data = d; ld_be = be;
        tick;
        ld_valid = 0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        req_valid = 1; req_pc = pc;
        tick;
        req_valid = 0;
    endtask

    initial begin
        reset = 1; ld_valid = 0; req_valid = 0; rsp_ready = 1; flush = 0;
        ld_addr = 0; ld_data = 0; ld_be = 0; req_pc = 0;
        repeat (2) tick;
        chk("reset_valid", rsp_valid, 0);
        chk("reset_inst", rsp_inst, NOP);
        chk("reset_pc", rsp_pc, 0);
        chk("reset_fault", rsp_fault, 0);
        chk("reset_cnt", fetch_cnt, 0);
        reset = 0;
        for (int w = 0; w < DEPTH / 4; w++) load(w * 4, $urandom, 4'hF);

        load(32'h0, 32'h00940333, 4'hF);
        load(32'h4, 32'h413903b3, 4'hF);
        req_valid = 1; req_pc = 32'h0;
        tick;
        chk("b2b_inst0", rsp_inst, 32'h00940333);
        chk("b2b_pc0", rsp_pc, 0);
        req_pc = 32'h4;
        tick;
        chk("b2b_inst1", rsp_inst, 32'h413903b3);
        chk("b2b_pc1", rsp_pc, 4);
        chk("b2b_fault1", rsp_fault, 0);
        req_valid = 0;
        tick;
        chk("b2b_cnt", fetch_cnt, 2);

        fetch(32'h2);
        chk("misal_inst", rsp_inst, NOP);
        chk("misal_fault", rsp_fault, 2'b01);
        fetch(32'h100);
        chk("oor_fault", rsp_fault, 2'b10);
        fetch(32'hFFFFFFFC);
        chk("wrap_fault", rsp_fault, 2'b10);
        chk("wrap_pc", rsp_pc, 32'hFFFFFFFC);
        tick;

        rsp_ready = 0;
        fetch(32'h0);
        load(32'h0, 32'hDEADBEEF, 4'hF);
        req_valid = 1; req_pc = 32'h0;
        tick;
        chk("hold_ready", req_ready, 0);
        chk("hold_inst", rsp_inst, 32'h00940333);
        rsp_ready = 1;
        tick;
        req_valid = 0;
        chk("raw_inst", rsp_inst, 32'hDEADBEEF);
        tick;

        load(32'h8, 32'h035a02b3, 4'hF);
        load(32'h8, 32'h0000AB00, 4'b0010);
        fetch(32'h8);
        chk("be_inst", rsp_inst, 32'h035aABb3);
        tick;

        ld_valid = 1; ld_addr = 32'h8; ld_data = 32'h11223344; ld_be = 4'hF;
        req_valid = 1; req_pc = 32'h8;
        #1;
        chk("ldprio_ready", req_ready, 0);
        tick;
        ld_valid = 0;
        tick;
        req_valid = 0;
        chk("ldprio_inst", rsp_inst, 32'h11223344);
        tick;

        rsp_ready = 0;
        fetch(32'h4);
        flush = 1;
        tick;
        flush = 0;
        chk("flush_valid", rsp_valid, 0);
        rsp_ready = 1;

        fetch(32'h0);
        reset = 1;
        tick;
        reset = 0;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_cnt", fetch_cnt, 0);
        fetch(32'h0);
        chk("rst_mem", rsp_inst, 32'hDEADBEEF);
        repeat (4) fetch(32'h4);
        tick;
        chk("sat_small", s_cnt, 3);
        chk("sat_wide", fetch_cnt, 5);

        repeat (600) begin
            int sel;
            reset     = ($urandom_range(0, 79) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            ld_valid  = ($urandom_range(0, 3) == 0);
            ld_addr   = $urandom_range(0, DEPTH + 31);
            ld_data   = $urandom;
            ld_be     = 4'($urandom);
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 7);
            req_pc = (sel < 5) ? ($urandom_range(0, DEPTH / 4 - 1) * 4) :
                     (sel == 5) ? $urandom_range(0, DEPTH - 1) :
                     (sel == 6) ? (DEPTH - 4 + $urandom_range(0, 8)) : ($urandom | 32'hFFFF0000);
            tick;
        end
        reset = 0; flush = 0; ld_valid = 0; req_valid = 0; rsp_ready = 1;
        repeat (3) tick;
        chk("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/imem_fetch.md
Name: imem_fetch

Overview:
Parametrised, byte-addressable, little-endian instruction memory with a valid/ready fetch port and a registered response stage. It adds a word-write load port for program download, misaligned and out-of-range fault reporting, a flush input for redirects, and a saturating fetch counter. It sits between the PC/fetch stage and decode, replacing the fixed 32-byte reset-initialised store.

Parameters:
DEPTH_BYTES, 256, memory size in bytes; multiple of 4, power of two
ADDR_W, 32, width of PC and load address
NOP_INST, 32'h00000013, instruction returned on a faulting fetch (addi x0,x0,0)
CNT_W, 16, width of fetch counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  reset, synchronous, active-high
ld_valid  in  1  load-port write strobe
ld_addr  in  ADDR_W  byte address of word to write; bits[1:0] ignored
ld_data  in  32  word to write, little-endian (byte0 = ld_data[7:0])
ld_be  in  4  byte enables for ld_data
req_valid  in  1  fetch request valid
req_ready  out  1  fetch request accepted when valid&ready
req_pc  in  ADDR_W  fetch byte address
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer ready
rsp_inst  out  32  {M[pc+3],M[pc+2],M[pc+1],M[pc]}, or NOP_INST on fault
rsp_pc  out  ADDR_W  PC of the response
rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range
fetch_cnt  out  CNT_W  count of responses consumed, saturating

Behaviour:
- Reset: rsp_valid=0, rsp_inst=NOP_INST, rsp_pc=0, rsp_fault=00, fetch_cnt=0. Memory contents are not cleared by reset. A response held at reset is dropped.
- Load: when ld_valid=1, write each byte lane with ld_be[i]=1 to M[{ld_addr[ADDR_W-1:2],2'b00}+i] on that edge. A word address >= DEPTH_BYTES is ignored silently. Loads are always accepted.
- Load priority: req_ready=0 in any cycle with ld_valid=1 or flush=1.
- req_ready = !ld_valid && !flush && (!rsp_valid || rsp_ready). This gives full throughput with one response in flight.
- Accept (req_valid&req_ready): on the next edge rsp_valid=1, rsp_pc=req_pc, and rsp_inst/rsp_fault load per the fault rules below. Latency is one cycle.
- Fault priority:
  - req_pc[1:0]!=0 -> 01, rsp_inst=NOP_INST.
  - else req_pc+3 >= DEPTH_BYTES -> 10, rsp_inst=NOP_INST.
  - else 00 with memory data.
  - Compute the range check at ADDR_W+1 bits so PC near 2^ADDR_W cannot wrap.
- Read-after-write: a fetch accepted in the cycle after a load sees the new bytes. Same-cycle conflict cannot occur because of load priority.
- Hold: while rsp_valid=1 and rsp_ready=0, all rsp_* outputs stay stable. Loads to the held address do not alter the held rsp_inst.
- Consume: when rsp_valid&rsp_ready and there is no new accept, rsp_valid->0 next edge. With a new accept in the same cycle, the next response replaces it back-to-back.
- Flush: flush=1 forces rsp_valid=0 on the next edge. No request is accepted that cycle. A response consumed in the same cycle as flush still counts.
- fetch_cnt: increments on each rsp_valid&rsp_ready, including faulting responses, and saturates at all-ones. Only reset clears it.

Test Plan:
- Load 0x00940333 at 0x0 and 0x413903b3 at 0x4 (be=F). Fetch 0x0 then 0x4 back-to-back with rsp_ready=1 -> responses 0x00940333/pc 0 and 0x413903b3/pc 4 on consecutive cycles, fault 00, fetch_cnt=2.
- Fetch pc=0x2 -> rsp_inst=0x00000013, rsp_fault=01. Fetch pc=DEPTH_BYTES (0x100) -> fault 10. Fetch pc=0xFFFFFFFC -> fault 10 with no wrap.
- Hold rsp_ready=0 for 3 cycles after a fetch of 0x0 -> req_ready=0, rsp_* stable. Meanwhile load 0xDEADBEEF to 0x0 -> held rsp_inst still 0x00940333. Release, then fetch 0x0 -> 0xDEADBEEF.
- ld_be=4'b0010 with ld_data=0x0000AB00 to 0x8 over 0x035a02b3 -> fetch 0x8 returns 0x035aABb3.
- ld_valid and req_valid asserted together -> req_ready=0 that cycle. The fetch is accepted the next cycle and returns the new data.
- Assert flush while a response is held, and separately assert reset mid-stream -> rsp_valid=0 next cycle. After reset, fetch_cnt=0 and earlier-loaded memory is still readable. With CNT_W=2, 5 consumes -> fetch_cnt=3.
